// File: rtl/ft601_fifo_responder.sv
// Device side of the FT601 32-bit synchronous 245-FIFO bus: RX FIFO (host->bus)
// and TX FIFO (bus->host) with registered rxf/txe flow control and sticky error flags.
module ft601_fifo_responder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          oe,
  input  logic          rd,
  input  logic          wr,
  input  logic [31:0]   data_in,
  input  logic [3:0]    be_in,
  output logic [31:0]   data_out,
  output logic          data_drv,
  output logic          rxf,
  output logic          txe,
  input  logic [31:0]   h_push_data,
  input  logic          h_push_valid,
  output logic          h_push_ready,
  output logic [31:0]   h_pop_data,
  output logic          h_pop_valid,
  input  logic          h_pop_ready,
  output logic [AW:0]   rx_level,
  output logic [AW:0]   tx_level,
  output logic [2:0]    err
);

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE  = AW'(1);

  logic [31:0]   rx_mem [DEPTH];
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [AW:0]   rx_level_nxt, tx_level_nxt;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic [31:0]   wr_word;

  assign rx_push = h_push_valid & h_push_ready;
  assign rx_pop  = ~oe & ~rd & ~rxf;
  assign tx_push = ~wr & ~txe & oe;
  assign tx_pop  = h_pop_valid & h_pop_ready;

  // Disabled byte lanes are stored as zero.
  for (genvar b = 0; b < 4; b++) begin : g_be
    assign wr_word[8*b +: 8] = be_in[b] ? data_in[8*b +: 8] : 8'h00;
  end

  assign data_out   = (rx_level == '0) ? '0 : rx_mem[rx_rp];
  assign h_pop_data = (tx_level == '0) ? '0 : tx_mem[tx_rp];

  always_comb begin
    rx_level_nxt = rx_level;
    tx_level_nxt = tx_level;
    if (rx_push && !rx_pop)      rx_level_nxt = rx_level + LONE;
    else if (!rx_push && rx_pop) rx_level_nxt = rx_level - LONE;
    if (tx_push && !tx_pop)      tx_level_nxt = tx_level + LONE;
    else if (!tx_push && tx_pop) tx_level_nxt = tx_level - LONE;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= h_push_data;
    if (tx_push) tx_mem[tx_wp] <= wr_word;
  end

  // Flags are registered from the post-update levels so they track the counters exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp        <= '0;
      rx_rp        <= '0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_level     <= '0;
      tx_level     <= '0;
      rxf          <= 1'b1;
      txe          <= 1'b1;
      h_push_ready <= 1'b0;
      h_pop_valid  <= 1'b0;
      data_drv     <= 1'b0;
      err          <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PONE;
      if (rx_pop)  rx_rp <= rx_rp + PONE;
      if (tx_push) tx_wp <= tx_wp + PONE;
      if (tx_pop)  tx_rp <= tx_rp + PONE;
      rx_level     <= rx_level_nxt;
      tx_level     <= tx_level_nxt;
      rxf          <= (rx_level_nxt == '0);
      txe          <= (tx_level_nxt == FULL);
      h_push_ready <= (rx_level_nxt != FULL);
      h_pop_valid  <= (tx_level_nxt != '0);
      data_drv     <= ~oe;
      err          <= err | {~wr & ~oe, ~wr & txe, ~rd & ~oe & rxf};
    end
  end

endmodule
